// File: rtl/tv_cap_pkg.sv
// Shared types and constants for the TV capture sequencer.
package tv_cap_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_GAP     = 2'd3
  } cap_state_t;

  localparam int LINE_W     = 10;
  localparam int LINE_EW    = 11;
  localparam int PIX_ACTIVE = 720;
endpackage

// File: rtl/tv_capture_sequencer.sv
// Arms on a host start, aligns to field boundaries, crops/decimates decoder pixels into the write FIFO.
// Optional: define TV_CAP_TESTPAT_EN to add iTESTPAT, which replaces pixel data with {line, pix} indices.
module tv_capture_sequencer
  import tv_cap_pkg::*;
#(
  parameter logic [9:0] V_START = 10'd0,
  parameter logic [9:0] V_LINES = 10'd240,
  parameter int         NFIELDS = 2
) (
  input  logic        iCLK_27,
  input  logic        iRST_N,
  input  logic        iSTART,
  input  logic        iSTOP,
  input  logic        iCONT,
  input  logic [1:0]  iHDEC,
  input  logic        iFVAL,
  input  logic [9:0]  iTV_Y,
  input  logic        iDVAL,
  input  logic [15:0] iYCbCr,
  input  logic        iWR_FULL,
`ifdef TV_CAP_TESTPAT_EN
  input  logic        iTESTPAT,
`endif
  output logic        oSKIP,
  output logic        oWR_EN,
  output logic [15:0] oWR_DATA,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oOVF,
  output logic [7:0]  oFIELD_CNT
);
  localparam logic [7:0] NF = 8'(NFIELDS);

  cap_state_t r_state, w_next;
  logic        r_fval_d, r_cont, r_stop_pend, r_ovf, r_wr_en;
  logic [9:0]  r_ty_d;
  logic [1:0]  r_phase, r_hdec;
  logic [15:0] r_wr_data;
  logic [7:0]  r_fcnt;

  logic        w_rise, w_fall, w_line_chg, w_in_win, w_keep, w_capt;
  logic        w_more, w_start, w_done, w_wr, w_drop;
  logic [1:0]  w_phase, w_hdec;
  logic [11:0] w_diff;
  logic [15:0] w_data;

  assign w_rise     = iFVAL & ~r_fval_d;
  assign w_fall     = ~iFVAL & r_fval_d;
  assign w_capt     = (r_state == S_CAPTURE);
  assign w_start    = (r_state == S_IDLE) & iSTART & ~iSTOP;
  assign w_more     = r_cont | (r_fcnt < NF);

  // Borrow bit of the 12-bit difference flags lines above the window start.
  assign w_diff     = {2'b00, iTV_Y} - {2'b00, V_START};
  assign w_in_win   = ~w_diff[11] & (w_diff[10:0] < {1'b0, V_LINES});

  // On the line-change cycle itself the phase and decimation setting restart.
  assign w_line_chg = (iTV_Y != r_ty_d);
  assign w_phase    = w_line_chg ? 2'd0 : r_phase;
  assign w_hdec     = w_line_chg ? iHDEC : r_hdec;
  assign w_keep     = iDVAL & w_in_win & (w_phase == 2'd0);
  assign w_wr       = w_keep & w_capt & ~iWR_FULL;
  assign w_drop     = w_keep & w_capt & iWR_FULL;

`ifdef TV_CAP_TESTPAT_EN
  logic [7:0] r_pix;
  logic [7:0] w_pix;
  assign w_pix  = w_line_chg ? 8'd0 : r_pix;
  assign w_data = iTESTPAT ? {w_diff[7:0], w_pix} : iYCbCr;

  always_ff @(posedge iCLK_27 or negedge iRST_N)
    if (!iRST_N)     r_pix <= 8'd0;
    else if (w_keep) r_pix <= w_pix + 8'd1;
    else             r_pix <= w_pix;
`else
  assign w_data = iYCbCr;
`endif

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_ARM;
      S_ARM:     if (iSTOP) w_next = S_IDLE;
                 else if (w_rise) w_next = S_CAPTURE;
      S_CAPTURE: if (w_fall) w_next = (r_stop_pend | iSTOP) ? S_IDLE : S_GAP;
      S_GAP: begin
        if (iSTOP) w_next = S_IDLE;
        else if (!w_more) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else if (w_rise) w_next = S_CAPTURE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK_27 or negedge iRST_N)
    if (!iRST_N) begin
      r_state     <= S_IDLE;
      r_fval_d    <= 1'b0;
      r_cont      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_ovf       <= 1'b0;
      r_wr_en     <= 1'b0;
      r_ty_d      <= 10'd0;
      r_phase     <= 2'd0;
      r_hdec      <= 2'd0;
      r_wr_data   <= 16'd0;
      r_fcnt      <= 8'd0;
    end else begin
      r_state  <= w_next;
      r_fval_d <= iFVAL;
      r_ty_d   <= iTV_Y;
      r_hdec   <= w_hdec;
      r_wr_en  <= w_wr;
      if (w_wr) r_wr_data <= w_data;
      if (w_start) begin
        r_cont <= iCONT;
        r_fcnt <= 8'd0;
      end else if (w_capt && w_fall) begin
        r_fcnt <= r_fcnt + 8'd1;
      end
      if (w_start)     r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
      if (!w_capt)     r_stop_pend <= 1'b0;
      else if (iSTOP)  r_stop_pend <= 1'b1;
      if (iDVAL && w_in_win) r_phase <= (w_phase == w_hdec) ? 2'd0 : w_phase + 2'd1;
      else if (w_line_chg)   r_phase <= 2'd0;
    end

  assign oSKIP      = (r_state != S_CAPTURE);
  assign oBUSY      = (r_state != S_IDLE);
  assign oDONE      = w_done;
  assign oWR_EN     = r_wr_en;
  assign oWR_DATA   = r_wr_data;
  assign oOVF       = r_ovf;
  assign oFIELD_CNT = r_fcnt;
endmodule
